quad_steer_gen: RTL and testbench

QUAD_STEER_GEN -- requirements
Module: quad_steer_gen

---
 rtl/quad_steer_gen.sv | 87 ++++++++
 tb/tb_quad_steer_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_steer_gen.sv
// quad_steer_gen: per-channel quadrature steering generator with position counters.
// Define QUAD_STEER_ACCEL_EN to shrink the step period toward div_min during a run.
module quad_steer_gen #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 16,
    parameter int POS_W       = 8,
    parameter int ACCEL_SHIFT = 3
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [DIV_W-1:0]          clkdiv,
    input  logic [DIV_W-1:0]          div_min,
    input  logic [CHANNELS-1:0]       left,
    input  logic [CHANNELS-1:0]       right,
    output logic [2*CHANNELS-1:0]     steer,
    output logic [POS_W*CHANNELS-1:0] pos,
    output logic [CHANNELS-1:0]       step
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN_R = 2'd1;
    localparam logic [1:0] RUN_L = 2'd2;

    logic [DIV_W-1:0] eff_div;
    assign eff_div = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
`ifdef QUAD_STEER_ACCEL_EN
    logic [DIV_W-1:0] eff_min;
    assign eff_min = (div_min == '0) ? DIV_W'(1) : div_min;
`else
    logic unused_div_min;
    assign unused_div_min = ^div_min;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [1:0]       state_q, state_d, phase_q, phase_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [POS_W-1:0] pos_q, pos_d;
        logic             step_q, step_d, fwd, go;
`ifdef QUAD_STEER_ACCEL_EN
        logic [DIV_W-1:0] per_q, per_d, shr, dec, sub, acc;
`endif
        always_comb begin
            fwd     = right[c] & ~left[c];
            state_d = fwd ? RUN_R : (left[c] & ~right[c]) ? RUN_L : IDLE;
            // a fresh entry or reversal steps at once; otherwise wait for the countdown
            go      = (state_d != IDLE) & ((state_d != state_q) | (cnt_q <= DIV_W'(1)));
            phase_d = go ? (fwd ? {phase_q[0], ~phase_q[1]} : {~phase_q[0], phase_q[1]}) : phase_q;
            pos_d   = go ? (fwd ? pos_q + 1'b1 : pos_q - 1'b1) : pos_q;
            step_d  = go;
`ifdef QUAD_STEER_ACCEL_EN
            shr   = per_q >> ACCEL_SHIFT;
            dec   = (shr == '0) ? DIV_W'(1) : shr;
            sub   = per_q - dec;
            acc   = (per_q <= eff_min) ? per_q : (sub < eff_min) ? eff_min : sub;
            per_d = (state_d == IDLE || state_d != state_q) ? eff_div : go ? acc : per_q;
            cnt_d = (state_d == IDLE) ? '0 : go ? per_d : cnt_q - 1'b1;
`else
            cnt_d = (state_d == IDLE) ? '0 : go ? eff_div : cnt_q - 1'b1;
`endif
        end

        always_ff @(posedge CLK) begin
            if (reset) begin
                state_q <= IDLE;
                phase_q <= '0;
                cnt_q   <= '0;
                pos_q   <= '0;
                step_q  <= 1'b0;
`ifdef QUAD_STEER_ACCEL_EN
                per_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                cnt_q   <= cnt_d;
                pos_q   <= pos_d;
                step_q  <= step_d;
`ifdef QUAD_STEER_ACCEL_EN
                per_q   <= per_d;
`endif
            end
        end

        assign steer[2*c +: 2]       = phase_q;
        assign pos[POS_W*c +: POS_W] = pos_q;
        assign step[c]               = step_q;
    end
endmodule

// File: tb/tb_quad_steer_gen.sv
// tb_quad_steer_gen: scoreboard bench for quad_steer_gen; a cycle model queues expected
// outputs per edge, and each scenario task pops and compares them plus fixed landmarks.
module tb_quad_steer_gen;
    localparam int CH = 2, DW = 16, PW = 8, SH = 3, EW = 2*CH + PW*CH + CH;

    logic CLK = 1'b0, reset;
    logic [DW-1:0] clkdiv, div_min;
    logic [CH-1:0] left, right;
    logic [2*CH-1:0] steer;
    logic [PW*CH-1:0] pos;
    logic [CH-1:0] step;

    always #5 CLK = ~CLK;

    quad_steer_gen #(.CHANNELS(CH), .DIV_W(DW), .POS_W(PW), .ACCEL_SHIFT(SH)) dut (
        .CLK(CLK), .reset(reset), .clkdiv(clkdiv), .div_min(div_min),
        .left(left), .right(right), .steer(steer), .pos(pos), .step(step)
    );

    int errors = 0, checks = 0;
    logic [EW-1:0] sbq[$];
    logic [EW-1:0] exp_v, got;
    int m_dir[CH], m_since[CH], m_per[CH], m_idx[CH];
    logic [PW-1:0] m_pos[CH];
    logic [1:0] gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic int next_per(int p, int cd, int dm);
`ifdef QUAD_STEER_ACCEL_EN
        int d, n;
        if (p <= dm) return p;
        d = p >> SH;
        if (d < 1) d = 1;
        n = p - d;
        return (n < dm) ? dm : n;
`else
        return cd;
`endif
    endfunction

    // drive one cycle of inputs, advance the model, queue its expectation
    task automatic tick(input logic rs, input logic [CH-1:0] l, input logic [CH-1:0] r);
        logic [2*CH-1:0] es;
        logic [PW*CH-1:0] ep;
        logic [CH-1:0] et;
        int d, cd, dm;
        @(negedge CLK);
        reset = rs; left = l; right = r;
        cd = (clkdiv == 0) ? 1 : int'(clkdiv);
        dm = (div_min == 0) ? 1 : int'(div_min);
        for (int c = 0; c < CH; c++) begin
            et[c] = 1'b0;
            d = (r[c] && !l[c]) ? 1 : (l[c] && !r[c]) ? 2 : 0;
            if (rs) begin
                m_dir[c] = 0; m_since[c] = 0; m_per[c] = 0; m_idx[c] = 0; m_pos[c] = '0;
            end else if (d == 0) begin
                m_dir[c] = 0;
            end else if (d != m_dir[c]) begin
                m_dir[c] = d; m_per[c] = cd; m_since[c] = 0; et[c] = 1'b1;
            end else begin
                m_since[c]++;
                if (m_since[c] >= m_per[c]) begin
                    m_since[c] = 0;
                    m_per[c] = next_per(m_per[c], cd, dm);
                    et[c] = 1'b1;
                end
            end
            if (et[c]) begin
                m_idx[c] = (d == 1) ? (m_idx[c] + 1) % 4 : (m_idx[c] + 3) % 4;
                m_pos[c] = (d == 1) ? m_pos[c] + 8'd1 : m_pos[c] - 8'd1;
            end
            es[2*c +: 2] = gray[m_idx[c]];
            ep[PW*c +: PW] = m_pos[c];
        end
        sbq.push_back({es, ep, et});
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        clkdiv = 4; div_min = 0;
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 2'b00, 2'b11);
            got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL reset_model k=%0d got=%h want=%h", k, got, exp_v); end
            checks++;
            if (got !== '0) begin errors++; $display("FAIL reset_zero k=%0d got=%h want=0", k, got); end
        end
    endtask

    task automatic test_basic;
        logic [1:0] want[5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        clkdiv = 4;
        tick(1'b1, 2'b00, 2'b00);
        void'(sbq.pop_front());
        for (int k = 1; k <= 17; k++) begin
            tick(1'b0, 2'b00, 2'b01);
            got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL basic_model k=%0d got=%h want=%h", k, got, exp_v); end
            if ((k - 1) % 4 == 0) begin
                checks++;
                if (steer[1:0] !== want[(k-1)/4] || step[0] !== 1'b1) begin
                    errors++; $display("FAIL basic_phase k=%0d got=%b/%b want=%b/1", k, steer[1:0], step[0], want[(k-1)/4]);
                end
            end
        end
        checks++;
        if (pos[7:0] !== 8'd5 || steer[3:2] !== 2'b00) begin
            errors++; $display("FAIL basic_end pos0=%0d steer1=%b want 5/00", pos[7:0], steer[3:2]);
        end
    endtask

    task automatic test_both;
        logic [1:0] ph;
        logic [7:0] ps;
        clkdiv = 4;
        tick(1'b1, 2'b00, 2'b00); void'(sbq.pop_front());
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 2'b00, 2'b01);
            got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL both_pre k=%0d got=%h want=%h", k, got, exp_v); end
        end
        ph = steer[1:0]; ps = pos[7:0];
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 2'b01, 2'b01);
            got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL both_model k=%0d got=%h want=%h", k, got, exp_v); end
            checks++;
            if (step[0] !== 1'b0 || steer[1:0] !== ph || pos[7:0] !== ps) begin
                errors++; $display("FAIL both_hold k=%0d got=%b/%b/%h want 0/%b/%h", k, step[0], steer[1:0], pos[7:0], ph, ps);
            end
        end
        tick(1'b0, 2'b01, 2'b00);
        got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL both_release got=%h want=%h", got, exp_v); end
        checks++;
        if (step[0] !== 1'b1 || pos[7:0] !== ps - 8'd1) begin
            errors++; $display("FAIL both_lstep got=%b/%h want 1/%h", step[0], pos[7:0], ps - 8'd1);
        end
    endtask

    task automatic test_reverse;
        clkdiv = 8;
        tick(1'b1, 2'b00, 2'b00); void'(sbq.pop_front());
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 2'b00, 2'b01);
            got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL rev_pre k=%0d got=%h want=%h", k, got, exp_v); end
        end
        for (int j = 1; j <= 20; j++) begin
            tick(1'b0, 2'b01, 2'b00);
            got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL rev_model j=%0d got=%h want=%h", j, got, exp_v); end
            checks++;
            if (step[0] !== ((j % 8) == 1)) begin
                errors++; $display("FAIL rev_spacing j=%0d got=%b want=%b", j, step[0], (j % 8) == 1);
            end
        end
    endtask

    task automatic test_reset_mid;
        clkdiv = 1;
        tick(1'b1, 2'b00, 2'b00); void'(sbq.pop_front());
        for (int k = 0; k < 34; k++) begin
            tick(1'b0, 2'b00, 2'b01);
            got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL rmid_model k=%0d got=%h want=%h", k, got, exp_v); end
        end
        checks++;
        if (steer[1:0] !== 2'b11 || pos[7:0] !== 8'h22) begin
            errors++; $display("FAIL rmid_pre got=%b/%h want 11/22", steer[1:0], pos[7:0]);
        end
        tick(1'b1, 2'b00, 2'b01);
        got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
        if (got !== '0 || exp_v !== '0) begin errors++; $display("FAIL rmid_abort got=%h want=0", got); end
        tick(1'b0, 2'b00, 2'b01);
        got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rmid_after got=%h want=%h", got, exp_v); end
        checks++;
        if (step[0] !== 1'b1 || steer[1:0] !== 2'b01 || pos[7:0] !== 8'd1) begin
            errors++; $display("FAIL rmid_fresh got=%b/%b/%h want 1/01/01", step[0], steer[1:0], pos[7:0]);
        end
    endtask

    task automatic test_fast;
        logic [2*CH-1:0] prev;
        clkdiv = 0;
        tick(1'b1, 2'b00, 2'b00); void'(sbq.pop_front());
        prev = steer;
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 2'b10, 2'b01);
            got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL fast_model k=%0d got=%h want=%h", k, got, exp_v); end
            checks++;
            if (step !== 2'b11 || steer[1:0] === prev[1:0] || steer[3:2] === prev[3:2]) begin
                errors++; $display("FAIL fast_step k=%0d got=%b steer=%b prev=%b want step 11", k, step, steer, prev);
            end
            prev = steer;
        end
    endtask

    task automatic test_accel;
        int ivs[$];
        int last_t;
        int want[5];
`ifdef QUAD_STEER_ACCEL_EN
        want = '{64, 56, 49, 43, 38};
`else
        want = '{64, 64, 64, 64, 64};
`endif
        clkdiv = 64; div_min = 16; last_t = -1;
        tick(1'b1, 2'b00, 2'b00); void'(sbq.pop_front());
        for (int t = 0; t < 620; t++) begin
            tick(1'b0, 2'b10, 2'b00);
            got = {steer, pos, step}; exp_v = sbq.pop_front(); checks++;
            if (got !== exp_v) begin errors++; $display("FAIL accel_model t=%0d got=%h want=%h", t, got, exp_v); end
            if (t == 0) begin
                checks++;
                if (pos[15:8] !== 8'hFF) begin errors++; $display("FAIL accel_wrap got=%h want=ff", pos[15:8]); end
            end
            if (step[1]) begin
                if (last_t >= 0) ivs.push_back(t - last_t);
                last_t = t;
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= ivs.size() || ivs[i] != want[i]) begin
                errors++; $display("FAIL accel_iv%0d got=%0d want=%0d", i, (i < ivs.size()) ? ivs[i] : -1, want[i]);
            end
        end
        for (int i = 1; i < ivs.size(); i++) begin
            checks++;
            if (ivs[i] > ivs[i-1]) begin errors++; $display("FAIL accel_mono i=%0d got=%0d prev=%0d", i, ivs[i], ivs[i-1]); end
        end
        checks++;
`ifdef QUAD_STEER_ACCEL_EN
        if (ivs.size() == 0 || ivs[ivs.size()-1] != 16) begin
            errors++; $display("FAIL accel_floor got=%0d want=16", (ivs.size() > 0) ? ivs[ivs.size()-1] : -1);
        end
`else
        if (ivs.size() == 0 || ivs[ivs.size()-1] != 64) begin
            errors++; $display("FAIL accel_floor got=%0d want=64", (ivs.size() > 0) ? ivs[ivs.size()-1] : -1);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; left = '0; right = '0; clkdiv = 4; div_min = 0;
        test_reset;
        test_basic;
        test_both;
        test_reverse;
        test_reset_mid;
        test_fast;
        test_accel;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
